// File: rtl/core_pkg.sv
// core_pkg: shared widths and register-file state encoding.
// Contents: default data/address widths and the INIT/RUN state type.
package core_pkg;

    localparam int CORE_DATA_W = 40;
    localparam int CORE_ADDR_W = 5;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: write-port priority select for one register.
// Ports:
//   wr_en_i/wr_addr_i/wr_data_i  all write ports, already gated to RUN
//   rsv_hit_i                    a reserve targets this register this cycle
//   hit_o                        some write port targets this register
//   data_o                       data of the highest-index hitting port
//   clr_o                        write clears busy (no competing reserve)
module regfile_wr_arb
    import core_pkg::*;
#(
    parameter int DATA_W  = CORE_DATA_W,
    parameter int ADDR_W  = CORE_ADDR_W,
    parameter int NUM_WR  = 2,
    parameter int REG_IDX = 0,
    parameter bit DROP    = 1'b0
) (
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_hit_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     clr_o
);

    // later iterations overwrite earlier ones, so the highest index wins
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (!DROP && wr_en_i[k] && wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_IDX)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // a reserve in the same cycle names a new producer, so busy must survive
    assign clr_o = hit_o && !rsv_hit_i;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with busy scoreboard and post-reset clear sweep.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rd_addr_i    NUM_RD read addresses; rd_data_o/rd_busy_o combinational results
//   wr_en_i, wr_addr_i, wr_data_i   NUM_WR write ports, higher index has priority
//   rsv_en_i, rsv_addr_i            reserve (mark busy) request from issue
//   ready_o      high once the clear sweep has finished
module regfile_mp_sb
    import core_pkg::*;
#(
    parameter int DATA_W   = CORE_DATA_W,
    parameter int ADDR_W   = CORE_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic                     ready_o
);

    // one extra bit so NUM_REGS == 2**ADDR_W still reaches its last index
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(NUM_REGS - 1);

    rf_state_e            state_q, state_d;
    logic [ADDR_W:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    wdata  [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d, hit, clr, rsv_hit;
    logic [NUM_WR-1:0]    wr_en_run;
    logic                 run;

    assign run       = state_q == RF_RUN;
    assign ready_o   = run;
    assign wr_en_run = wr_en_i & {NUM_WR{run}};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign rsv_hit[g] = run && rsv_en_i && rsv_addr_i == ADDR_W'(g) && !(ZERO_REG && g == 0);
        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR),
            .REG_IDX(g),
            .DROP   (ZERO_REG && g == 0)
        ) u_arb (
            .wr_en_i  (wr_en_run),
            .wr_addr_i(wr_addr_i),
            .wr_data_i(wr_data_i),
            .rsv_hit_i(rsv_hit[g]),
            .hit_o    (hit[g]),
            .data_o   (wdata[g]),
            .clr_o    (clr[g])
        );
    end

    assign busy_d = rsv_hit | (busy_q & ~clr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_LAST) ? RF_RUN : RF_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // storage has no reset; the INIT sweep zeroes one register per cycle
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!rst) begin
                if (!run && cnt_q == (ADDR_W+1)'(r))
                    regs_q[r] <= '0;
                else if (hit[r])
                    regs_q[r] <= wdata[r];
            end
        end
    end

    // out-of-range addresses match no register and fall through to zero
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (run && rd_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(r) && !(ZERO_REG && r == 0)) begin
                    rd_data_o[i*DATA_W +: DATA_W] = (BYPASS && hit[r]) ? wdata[r] : regs_q[r];
                    rd_busy_o[i] = busy_q[r] && !(BYPASS && clr[r]);
                end
            end
        end
    end

endmodule
